// File: rtl/multi_delay_pkg.sv
// Shared types and constants for the multi-channel delay timer.
// The DELAY_ASSERT_EN macro enables the formal properties in multi_delay and delay_chan.
package multi_delay_pkg;

   localparam int CBITS_DEF = 17;
   localparam int N_DEF     = 100000;

   typedef logic [CBITS_DEF-1:0] cnt_t;

   // Width of a channel index; a single channel still gets a 1-bit select.
   function automatic int ch_idx_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

endpackage

// File: rtl/multi_delay_chan.sv
// One delay channel: counter, period register, fire/done logic and sticky status.
// DELAY_ASSERT_EN compiles in the per-channel bound and one-shot properties.
module delay_chan
   import multi_delay_pkg::*;
#(
   parameter int CBITS = CBITS_DEF,
   parameter int N     = N_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             oneshot,
   input  logic             load,
   input  logic [CBITS-1:0] load_val,
   input  logic             ack,
   output logic             sig,
   output logic             done,
   output logic             stat
);

   logic [CBITS-1:0] cnt_q, cnt_d;
   logic [CBITS-1:0] per_q, per_d;
   logic             sig_q, sig_d;
   logic             done_q, done_d;
   logic             stat_q, stat_d;
   logic             fire;

   always_comb begin
      cnt_d  = cnt_q;
      sig_d  = 1'b0;
      done_d = done_q;
      fire   = 1'b0;
      if (clr) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (done_q) begin
         cnt_d = '0;
      end else if (en && (cnt_q >= per_q)) begin
         // >= rather than == so a period lowered below cnt fires instead of wrapping
         fire  = 1'b1;
         cnt_d = '0;
         sig_d = 1'b1;
         if (oneshot) done_d = 1'b1;
      end else if (en) begin
         cnt_d = cnt_q + CBITS'(1);
      end
      per_d  = load ? load_val : per_q;
      stat_d = fire ? 1'b1 : (ack ? 1'b0 : stat_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         per_q  <= CBITS'(N);
         sig_q  <= 1'b0;
         done_q <= 1'b0;
         stat_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         per_q  <= per_d;
         sig_q  <= sig_d;
         done_q <= done_d;
         stat_q <= stat_d;
      end
   end

   assign sig  = sig_q;
   assign done = done_q;
   assign stat = stat_q;

`ifdef DELAY_ASSERT_EN
   a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
      !$past(load && (load_val < per_q)) |-> (cnt_q <= per_q));

   a_oneshot_once: assert property (@(posedge clk) disable iff (rst)
      (done_q && !clr) |=> !sig_q);
`else
`endif

endmodule

// File: rtl/multi_delay.sv
// Multi-channel programmable delay timer: NCH delay_chan instances, load decode and irq.
// DELAY_ASSERT_EN compiles in the liveness and irq properties.
module multi_delay
   import multi_delay_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int CBITS = CBITS_DEF,
   parameter int N     = N_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NCH-1:0]             clr,
   input  logic [NCH-1:0]             en,
   input  logic [NCH-1:0]             oneshot,
   input  logic                       load,
   input  logic [ch_idx_w(NCH)-1:0]   load_ch,
   input  logic [CBITS-1:0]           load_val,
   input  logic [NCH-1:0]             ack,
   output logic [NCH-1:0]             sig,
   output logic [NCH-1:0]             done,
   output logic [NCH-1:0]             stat,
   output logic                       irq
);

   localparam int IW = ch_idx_w(NCH);

   logic [NCH-1:0] load_sel;
   logic           irq_q, irq_d;

   // Only indices below NCH are ever matched, so out-of-range loads fall away.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         assign load_sel[gi] = load && (load_ch == IW'(gi));

         delay_chan #(
            .CBITS (CBITS),
            .N     (N)
         ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr[gi]),
            .en       (en[gi]),
            .oneshot  (oneshot[gi]),
            .load     (load_sel[gi]),
            .load_val (load_val),
            .ack      (ack[gi]),
            .sig      (sig[gi]),
            .done     (done[gi]),
            .stat     (stat[gi])
         );
      end
   endgenerate

   assign irq_d = |stat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= irq_d;
   end

   assign irq = irq_q;

`ifdef DELAY_ASSERT_EN
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_live
         a_live: assert property (@(posedge clk) disable iff (rst)
            (en[gi] && !oneshot[gi]) |-> s_eventually (clr[gi] || sig[gi]));
      end
   endgenerate

   a_irq: assert property (@(posedge clk) disable iff (rst)
      !$past(rst) |-> (irq == $past(|stat)));
`else
`endif

endmodule

// File: tb/tb_multi_delay.sv
// Scoreboard bench for multi_delay: expected sig pulses are queued as (channel, edge)
// and checked by a negedge monitor; each scenario task also checks status inline.
module tb_multi_delay;

   localparam int NCH   = 4;
   localparam int CBITS = 17;
   localparam int N     = 20;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH-1:0]   clr, en, oneshot, ack;
   logic             load;
   logic [1:0]       load_ch;
   logic [CBITS-1:0] load_val;
   logic [NCH-1:0]   sig, done, stat;
   logic             irq;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   typedef struct {
      int ch;
      int e_at;
   } exp_t;
   exp_t exp_q[$];

   multi_delay #(
      .NCH   (NCH),
      .CBITS (CBITS),
      .N     (N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (en),
      .oneshot  (oneshot),
      .load     (load),
      .load_ch  (load_ch),
      .load_val (load_val),
      .ack      (ack),
      .sig      (sig),
      .done     (done),
      .stat     (stat),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Scoreboard monitor: every sig pulse must match the head of the queue.
   always @(negedge clk) begin
      if (!rst) begin
         while (exp_q.size() > 0 && exp_q[0].e_at < edge_n) begin
            checks++;
            errors++;
            $display("FAIL sig_missing ch%0d: no pulse seen, required at edge %0d (now %0d)",
                     exp_q[0].ch, exp_q[0].e_at, edge_n);
            void'(exp_q.pop_front());
         end
         for (int c = 0; c < NCH; c++) begin
            if (sig[c]) begin
               checks++;
               if (exp_q.size() == 0 || exp_q[0].ch != c || exp_q[0].e_at != edge_n) begin
                  errors++;
                  $display("FAIL sig_unexpected: pulse on ch%0d at edge %0d, required ch%0d edge %0d",
                           c, edge_n, (exp_q.size() > 0) ? exp_q[0].ch : -1,
                           (exp_q.size() > 0) ? exp_q[0].e_at : -1);
               end else begin
                  $display("sig ch%0d at edge %0d ok", c, edge_n);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int ch, input int e_at);
      exp_t x;
      x.ch   = ch;
      x.e_at = e_at;
      exp_q.push_back(x);
   endtask

   task automatic do_load(input int ch, input int val);
      load     = 1'b1;
      load_ch  = 2'(ch);
      load_val = CBITS'(val);
      step(1);
      load     = 1'b0;
   endtask

   task automatic test_reset();
      step(2);
      checks++;
      if ({sig, done, stat, irq} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: sig=%b done=%b stat=%b irq=%b, required all 0", sig, done, stat, irq);
      end else $display("reset outputs ok");
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_periodic();
      int e0;
      en[0] = 1'b1;
      e0 = edge_n;
      push(0, e0 + 21);
      push(0, e0 + 42);
      push(0, e0 + 63);
      step(21);
      checks++;
      if (stat[0] !== 1'b1 || irq !== 1'b0) begin
         errors++;
         $display("FAIL periodic_stat: stat0=%b irq=%b, required stat0=1 irq=0", stat[0], irq);
      end else $display("periodic stat set ok");
      step(1);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("FAIL periodic_irq: irq=%b, required 1", irq);
      end else $display("periodic irq ok");
      step(41);
      en[0] = 1'b0;
      step(1);
   endtask

   task automatic test_ack();
      int e0;
      ack[0] = 1'b1;
      step(1);
      ack[0] = 1'b0;
      checks++;
      if (stat[0] !== 1'b0) begin
         errors++;
         $display("FAIL ack_clear: stat0=%b, required 0", stat[0]);
      end else $display("ack clear ok");
      step(1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL ack_irq_clear: irq=%b, required 0", irq);
      end else $display("ack irq clear ok");
      do_load(0, 2);
      en[0] = 1'b1;
      e0 = edge_n;
      push(0, e0 + 3);
      step(2);
      ack[0] = 1'b1;
      step(1);
      checks++;
      if (stat[0] !== 1'b1) begin
         errors++;
         $display("FAIL ack_set_wins: stat0=%b, required 1", stat[0]);
      end else $display("fire with ack keeps stat ok");
      en[0] = 1'b0;
      step(1);
      ack[0] = 1'b0;
      checks++;
      if (stat[0] !== 1'b0 || irq !== 1'b1) begin
         errors++;
         $display("FAIL ack_next: stat0=%b irq=%b, required stat0=0 irq=1", stat[0], irq);
      end else $display("ack next cycle ok");
      step(1);
      checks++;
      if (irq !== 1'b0) begin
         errors++;
         $display("FAIL ack_irq_lag: irq=%b, required 0", irq);
      end else $display("irq follows stat ok");
   endtask

   task automatic test_oneshot();
      int e0, c0;
      do_load(1, 3);
      en[1]      = 1'b1;
      oneshot[1] = 1'b1;
      e0 = edge_n;
      push(1, e0 + 4);
      step(4);
      checks++;
      if (done[1] !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_done: done1=%b, required 1", done[1]);
      end else $display("oneshot done ok");
      step(8);
      checks++;
      if (done[1] !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_halt: done1=%b, required 1", done[1]);
      end else $display("oneshot halted ok");
      clr[1] = 1'b1;
      c0 = edge_n;
      step(1);
      clr[1] = 1'b0;
      checks++;
      if (done[1] !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_clr: done1=%b, required 0", done[1]);
      end else $display("oneshot clr ok");
      push(1, c0 + 5);
      step(4);
      checks++;
      if (done[1] !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_refire: done1=%b, required 1", done[1]);
      end else $display("oneshot refire ok");
      en[1] = 1'b0;
      step(1);
   endtask

   task automatic test_lower_per();
      int e0;
      do_load(2, 100);
      en[2] = 1'b1;
      e0 = edge_n;
      step(50);
      en[2]    = 1'b0;
      load     = 1'b1;
      load_ch  = 2'd2;
      load_val = CBITS'(20);
      step(1);
      load  = 1'b0;
      en[2] = 1'b1;
      push(2, e0 + 52);
      step(1);
      checks++;
      if (sig[2] !== 1'b1) begin
         errors++;
         $display("FAIL lower_per_fire: sig2=%b, required 1", sig[2]);
      end else $display("lowered period fires ok");
      step(3);
      load     = 1'b1;
      load_ch  = 2'd2;
      load_val = '0;
      step(1);
      load = 1'b0;
      for (int k = 57; k <= 62; k++) push(2, e0 + k);
      step(6);
      en[2] = 1'b0;
      step(1);
      checks++;
      if (sig[2] !== 1'b0) begin
         errors++;
         $display("FAIL per0_stop: sig2=%b, required 0", sig[2]);
      end else $display("per0 stops with en low ok");
   endtask

   task automatic test_en_toggle();
      int e0;
      do_load(3, 5);
      e0 = edge_n;
      push(3, e0 + 11);
      for (int i = 0; i < 12; i++) begin
         en[3] = (i % 2 == 0);
         step(1);
      end
      en[3] = 1'b0;
      checks++;
      if (stat[3] !== 1'b1) begin
         errors++;
         $display("FAIL en_toggle_stat: stat3=%b, required 1", stat[3]);
      end else $display("en toggle fired ok");
   endtask

   task automatic test_load_fire();
      int f0;
      en[3] = 1'b1;
      f0 = edge_n;
      push(3, f0 + 6);
      step(5);
      load     = 1'b1;
      load_ch  = 2'd3;
      load_val = CBITS'(8);
      step(1);
      load = 1'b0;
      checks++;
      if (sig[3] !== 1'b1) begin
         errors++;
         $display("FAIL load_fire_old_per: sig3=%b, required 1", sig[3]);
      end else $display("fire with simultaneous load uses old period ok");
      push(3, f0 + 15);
      step(9);
      en[3] = 1'b0;
      step(1);
   endtask

   task automatic test_rst_mid();
      int r0;
      checks++;
      if (irq !== 1'b1 || done[1] !== 1'b1) begin
         errors++;
         $display("FAIL pre_rst_state: irq=%b done1=%b, required 1 1", irq, done[1]);
      end else $display("pre-reset state ok");
      en[3] = 1'b1;
      step(3);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({sig, done, stat, irq} !== '0) begin
         errors++;
         $display("FAIL async_rst: sig=%b done=%b stat=%b irq=%b, required all 0", sig, done, stat, irq);
      end else $display("async reset clears outputs ok");
      @(negedge clk);
      rst        = 1'b0;
      oneshot    = '0;
      exp_q.delete();
      r0 = edge_n;
      push(3, r0 + 21);
      step(21);
      checks++;
      if (stat[3] !== 1'b1) begin
         errors++;
         $display("FAIL rst_per_restore: stat3=%b, required 1", stat[3]);
      end else $display("period restored to N ok");
      en = '0;
      step(2);
   endtask

   initial begin
      rst      = 1'b1;
      clr      = '0;
      en       = '0;
      oneshot  = '0;
      ack      = '0;
      load     = 1'b0;
      load_ch  = '0;
      load_val = '0;
      test_reset();
      test_periodic();
      test_ack();
      test_oneshot();
      test_lower_per();
      test_en_toggle();
      test_load_fire();
      test_rst_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
